// File: rtl/lcd_bus_reader.sv
// -----------------------------------------------------------------------------
// lcd_bus_reader
//
// Read-side engine for an HD44780-style 16x2 LCD parallel bus. It sits beside
// the init/write controller, which only ever drives the bus. This block runs
// timed read cycles (RW=1) and returns one byte per request:
//   - RS=0: busy flag (DB7) plus address counter (DB6..DB0)
//   - RS=1: DDRAM/CGRAM data at the current address
// With req_wait_bf_i set on an RS=0 request, the read repeats until DB7 reads
// 0, so the writer can wait on the real busy flag instead of fixed delays.
//
// Each read pulse is: T_AS cycles of address setup (E low), T_PW cycles of
// E high (the bus is sampled on the last of these), then T_GAP cycles of E low.
//
// Build option:
//   LCD_BUSY_TIMEOUT_EN - when defined, busy polling gives up after POLL_MAX
//                         samples and flags rsp_timeout_o. When undefined,
//                         polling is unbounded and rsp_timeout_o is tied low.
//
// Ports:
//   clk_i          system clock (20 MHz)
//   rst_i          synchronous active-high reset
//   req_valid_i    read request; accepted when req_ready_o is also high
//   req_ready_o    block idle and able to accept a request
//   req_rs_i       0 = busy-flag/address read, 1 = data read
//   req_wait_bf_i  with req_rs_i=0: repeat reads until DB7=0
//   rsp_valid_o    one-cycle completion pulse
//   rsp_data_o     last sampled bus value, held until the next completion
//   rsp_timeout_o  qualifies rsp_valid_o: busy polling gave up
//   bus_active_o   block owns the bus (top-level mux releases DATA, routes
//                  this block's RS/RW/E)
//   lcd_rs_o       LCD register select
//   lcd_rw_o       LCD read/write (1 = read)
//   lcd_e_o        LCD enable strobe
//   lcd_db_in_i    LCD data bus, input side of the top-level tristate
// -----------------------------------------------------------------------------
module lcd_bus_reader #(
    parameter int unsigned T_AS     = 2,      // RS/RW setup before E rises
    parameter int unsigned T_PW     = 10,     // E high time
    parameter int unsigned T_GAP    = 20,     // E low time after each pulse
    parameter int unsigned POLL_MAX = 20000   // busy samples per request (timeout build)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rs_i,
    input  logic       req_wait_bf_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_timeout_o,
    output logic       bus_active_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    input  logic [7:0] lcd_db_in_i
);

    // -------------------------------------------------------------------------
    // Parameter sanity: every phase must last at least one cycle and fit the
    // 16-bit phase timer (which is loaded with length-1).
    // -------------------------------------------------------------------------
    generate
        if (T_AS < 1 || T_PW < 1 || T_GAP < 1 || POLL_MAX < 1 ||
            T_AS > 65536 || T_PW > 65536 || T_GAP > 65536) begin : g_bad_params
            $error("lcd_bus_reader: T_AS/T_PW/T_GAP must be 1..65536 and POLL_MAX >= 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_E_HIGH = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Phase timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [15:0] T_AS_LD  = 16'(T_AS - 1);
    localparam logic [15:0] T_PW_LD  = 16'(T_PW - 1);
    localparam logic [15:0] T_GAP_LD = 16'(T_GAP - 1);

`ifdef LCD_BUSY_TIMEOUT_EN
    localparam int unsigned      POLL_W     = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
    localparam logic [POLL_W-1:0] POLL_MAX_C = POLL_W'(POLL_MAX);
`endif

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]  state_q,    state_d;
    logic [15:0] timer_q,    timer_d;
    logic        rs_q,       rs_d;        // captured request RS
    logic        wait_bf_q,  wait_bf_d;   // captured request wait-for-BF
    logic [7:0]  sample_q,   sample_d;    // most recent bus sample
    logic [7:0]  rsp_data_q, rsp_data_d;  // value presented on completion
    logic        ready_q,    ready_d;
`ifdef LCD_BUSY_TIMEOUT_EN
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic              timeout_q,  timeout_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rs_d       = rs_q;
        wait_bf_d  = wait_bf_q;
        sample_d   = sample_q;
        rsp_data_d = rsp_data_q;
`ifdef LCD_BUSY_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Request fields are only looked at on the accepting edge.
                if (req_valid_i && ready_q) begin
                    state_d   = S_SETUP;
                    timer_d   = T_AS_LD;
                    rs_d      = req_rs_i;
                    wait_bf_d = req_wait_bf_i;
`ifdef LCD_BUSY_TIMEOUT_EN
                    poll_cnt_d = POLL_W'(1);
                    timeout_d  = 1'b0;
`endif
                end
            end

            S_SETUP: begin
                if (timer_q == 16'd0) begin
                    state_d = S_E_HIGH;
                    timer_d = T_PW_LD;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end

            S_E_HIGH: begin
                if (timer_q == 16'd0) begin
                    // Last cycle with E high: the LCD is still driving DB.
                    state_d  = S_HOLD;
                    timer_d  = T_GAP_LD;
                    sample_d = lcd_db_in_i;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end

            S_HOLD: begin
                if (timer_q == 16'd0) begin
                    // Only a status read can poll; wait_bf is meaningless for data reads.
                    if (!rs_q && wait_bf_q && sample_q[7]) begin
`ifdef LCD_BUSY_TIMEOUT_EN
                        if (poll_cnt_q == POLL_MAX_C) begin
                            state_d    = S_DONE;
                            rsp_data_d = sample_q;
                            timeout_d  = 1'b1;
                        end else begin
                            state_d    = S_SETUP;
                            timer_d    = T_AS_LD;
                            poll_cnt_d = poll_cnt_q + POLL_W'(1);
                        end
`else
                        state_d = S_SETUP;
                        timer_d = T_AS_LD;
`endif
                    end else begin
                        state_d    = S_DONE;
                        rsp_data_d = sample_q;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
`ifdef LCD_BUSY_TIMEOUT_EN
                timeout_d = 1'b0;
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Ready is registered so it stays low for one cycle after reset and
        // rises in the cycle after DONE.
        ready_d = (state_d == S_IDLE);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            rs_q       <= 1'b0;
            wait_bf_q  <= 1'b0;
            sample_q   <= 8'h00;
            rsp_data_q <= 8'h00;
            ready_q    <= 1'b0;
`ifdef LCD_BUSY_TIMEOUT_EN
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rs_q       <= rs_d;
            wait_bf_q  <= wait_bf_d;
            sample_q   <= sample_d;
            rsp_data_q <= rsp_data_d;
            ready_q    <= ready_d;
`ifdef LCD_BUSY_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded straight from the state register, so a reset edge
    // drops E, RW and bus ownership immediately.
    // -------------------------------------------------------------------------
    logic in_cycle;
    assign in_cycle = (state_q == S_SETUP) || (state_q == S_E_HIGH) || (state_q == S_HOLD);

    assign req_ready_o  = ready_q;
    assign bus_active_o = in_cycle;
    assign lcd_rw_o     = in_cycle;
    assign lcd_rs_o     = in_cycle && rs_q;
    assign lcd_e_o      = (state_q == S_E_HIGH);
    assign rsp_valid_o  = (state_q == S_DONE);
    assign rsp_data_o   = rsp_data_q;
`ifdef LCD_BUSY_TIMEOUT_EN
    assign rsp_timeout_o = (state_q == S_DONE) && timeout_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_reader.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_reader
//
// Directed bench for lcd_bus_reader with default timing (T_AS=2, T_PW=10,
// T_GAP=20). Expected responses (data, timeout flag, completion cycle counted
// from the accepting edge) are queued when a request is driven and compared
// when rsp_valid_o appears. Bus-pin activity is traced per cycle and checked
// after each transaction. Build with LCD_BUSY_TIMEOUT_EN to exercise the
// POLL_MAX=4 give-up path instead of the unbounded polling path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_bus_reader;

`ifdef LCD_BUSY_TIMEOUT_EN
    localparam int unsigned TB_POLL_MAX = 4;
`else
    localparam int unsigned TB_POLL_MAX = 20000;
`endif

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready_o;
    logic       req_rs;
    logic       req_wait_bf;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic       rsp_timeout_o;
    logic       bus_active_o;
    logic       lcd_rs_o;
    logic       lcd_rw_o;
    logic       lcd_e_o;
    logic [7:0] lcd_db_in;

    lcd_bus_reader #(
        .T_AS    (2),
        .T_PW    (10),
        .T_GAP   (20),
        .POLL_MAX(TB_POLL_MAX)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_rs_i     (req_rs),
        .req_wait_bf_i(req_wait_bf),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_timeout_o(rsp_timeout_o),
        .bus_active_o (bus_active_o),
        .lcd_rs_o     (lcd_rs_o),
        .lcd_rw_o     (lcd_rw_o),
        .lcd_e_o      (lcd_e_o),
        .lcd_db_in_i  (lcd_db_in)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;   // 20 MHz

    // Scoreboard
    typedef struct {
        logic [7:0] data;
        logic       timeout;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Per-transaction trace statistics
    int cyc;
    int e_cnt, e_first, e_last;
    int e_rises, rise_first, rise_last;
    logic e_prev;
    int rw_cnt, rw_first, rw_last;
    int rs_cnt, rs_first, rs_last;
    int rsp_cnt;
    int ready_first;

    // Bus model: first n_busy E pulses see busy_v, later ones see final_v
    logic [7:0] busy_v, final_v;
    int n_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0;
        e_cnt = 0; e_first = -1; e_last = -1;
        e_rises = 0; rise_first = -1; rise_last = -1; e_prev = 1'b0;
        rw_cnt = 0; rw_first = -1; rw_last = -1;
        rs_cnt = 0; rs_first = -1; rs_last = -1;
        rsp_cnt = 0; ready_first = -1;
    endtask

    // Advance one clock and observe the DUT 1 ns after the edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (lcd_e_o) begin
            e_cnt++;
            if (e_first < 0) e_first = cyc;
            e_last = cyc;
            if (!e_prev) begin
                e_rises++;
                if (rise_first < 0) rise_first = cyc;
                rise_last = cyc;
            end
        end
        e_prev = lcd_e_o;
        if (lcd_rw_o) begin
            rw_cnt++;
            if (rw_first < 0) rw_first = cyc;
            rw_last = cyc;
        end
        if (lcd_rs_o) begin
            rs_cnt++;
            if (rs_first < 0) rs_first = cyc;
            rs_last = cyc;
        end
        if (req_ready_o && ready_first < 0) ready_first = cyc;
        lcd_db_in = (e_rises <= n_busy) ? busy_v : final_v;
        if (rsp_valid_o) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", 32'(rsp_data_o), 32'(e.data));
                chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e.timeout));
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    endtask

    // One complete read: request accepted on edge 0, then run to completion.
    task automatic run_read(input logic rs, input logic wbf,
                            input logic [7:0] bv, input logic [7:0] fv, input int nb,
                            input logic [7:0] exp_d, input logic exp_to,
                            input int exp_c, input int budget);
        clear_stats();
        busy_v = bv; final_v = fv; n_busy = nb;
        lcd_db_in = (nb > 0) ? bv : fv;
        sb.push_back('{data: exp_d, timeout: exp_to, cyc: exp_c});
        req_rs = rs; req_wait_bf = wbf; req_valid = 1'b1;
        step();
        // Change the request fields after acceptance; they must be ignored.
        req_valid = 1'b0; req_rs = ~rs; req_wait_bf = ~wbf;
        while (rsp_cnt == 0 && cyc < budget) step();
        chk("rsp_within_budget", 32'(rsp_cnt), 32'd1);
        step();
        chk("ready_after_done", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_wait_bf = 1'b0;
        lcd_db_in = 8'h00; busy_v = 8'h00; final_v = 8'h00; n_busy = 0;
        clear_stats();

        // ---- Reset state ----
        step(); step();
        chk("rst_lcd_e", 32'(lcd_e_o), 32'd0);
        chk("rst_lcd_rw", 32'(lcd_rw_o), 32'd0);
        chk("rst_lcd_rs", 32'(lcd_rs_o), 32'd0);
        chk("rst_bus_active", 32'(bus_active_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data_o), 32'h00);
        chk("rst_rsp_timeout", 32'(rsp_timeout_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(req_ready_o), 32'd1);
        $display("reset: ready=%0b", req_ready_o);

        // ---- Single status read, no polling ----
        run_read(1'b0, 1'b0, 8'h25, 8'h25, 0, 8'h25, 1'b0, 33, 200);
        chk("t1_e_cycles", e_cnt, 10);
        chk("t1_e_first", e_first, 3);
        chk("t1_e_last", e_last, 12);
        chk("t1_rw_cycles", rw_cnt, 32);
        chk("t1_rw_first", rw_first, 1);
        chk("t1_rw_last", rw_last, 32);
        chk("t1_rs_cycles", rs_cnt, 0);
        $display("txn status-read: data=%02h pulses=%0d", rsp_data_o, e_rises);

        // ---- Data read with wait_bf set (ignored) ----
        run_read(1'b1, 1'b1, 8'h48, 8'h48, 0, 8'h48, 1'b0, 33, 200);
        chk("t2_pulses", e_rises, 1);
        chk("t2_rs_cycles", rs_cnt, 32);
        chk("t2_rs_first", rs_first, 1);
        chk("t2_rs_last", rs_last, 32);
        $display("txn data-read: data=%02h pulses=%0d", rsp_data_o, e_rises);

        // ---- Data read whose value has bit 7 set: still one pulse ----
        run_read(1'b1, 1'b1, 8'hC8, 8'hC8, 0, 8'hC8, 1'b0, 33, 200);
        chk("t2b_pulses", e_rises, 1);
        $display("txn data-read-bit7: data=%02h pulses=%0d", rsp_data_o, e_rises);

        // ---- Busy polling: three busy samples, then ready ----
        run_read(1'b0, 1'b1, 8'h80, 8'h07, 3, 8'h07, 1'b0, 129, 400);
        chk("t3_pulses", e_rises, 4);
        chk("t3_first_rise", rise_first, 3);
        chk("t3_pulse_span", rise_last - rise_first, 96);
        chk("t3_e_cycles", e_cnt, 40);
        $display("txn poll: data=%02h pulses=%0d", rsp_data_o, e_rises);

`ifdef LCD_BUSY_TIMEOUT_EN
        // ---- Busy stuck: give up after POLL_MAX samples ----
        run_read(1'b0, 1'b1, 8'hC0, 8'hC0, 1000, 8'hC0, 1'b1, 129, 400);
        chk("t4_pulses", e_rises, 4);
        $display("txn poll-timeout: data=%02h pulses=%0d", rsp_data_o, e_rises);
`else
        // ---- Busy for 105 samples: polling keeps going past 100 ----
        run_read(1'b0, 1'b1, 8'hC0, 8'h00, 105, 8'h00, 1'b0, 33 + 105 * 32, 4000);
        chk("t4_pulses", e_rises, 106);
        $display("txn long-poll: data=%02h pulses=%0d", rsp_data_o, e_rises);
`endif

        // ---- Back-to-back: req_valid held high for two requests ----
        clear_stats();
        busy_v = 8'h5A; final_v = 8'h5A; n_busy = 0; lcd_db_in = 8'h5A;
        sb.push_back('{data: 8'h5A, timeout: 1'b0, cyc: 33});
        sb.push_back('{data: 8'h5A, timeout: 1'b0, cyc: 67});
        req_rs = 1'b0; req_wait_bf = 1'b0; req_valid = 1'b1;
        step();
        while (cyc < 35) step();
        req_valid = 1'b0;
        while (cyc < 100) step();
        chk("b2b_ready_first", ready_first, 34);
        chk("b2b_rsp_count", rsp_cnt, 2);
        chk("b2b_pulses", e_rises, 2);
        chk("b2b_second_rise", rise_last, 37);
        $display("txn back-to-back: responses=%0d pulses=%0d", rsp_cnt, e_rises);

        // ---- Reset while E is high ----
        clear_stats();
        busy_v = 8'h3C; final_v = 8'h3C; n_busy = 0; lcd_db_in = 8'h3C;
        req_rs = 1'b0; req_wait_bf = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        while (cyc < 7) step();
        chk("rmid_e_high_c7", 32'(lcd_e_o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmid_lcd_e_c8", 32'(lcd_e_o), 32'd0);
        chk("rmid_lcd_rw_c8", 32'(lcd_rw_o), 32'd0);
        chk("rmid_bus_active_c8", 32'(bus_active_o), 32'd0);
        step();
        chk("rmid_ready_c9", 32'(req_ready_o), 32'd1);
        while (cyc < 60) step();
        chk("rmid_no_rsp", rsp_cnt, 0);
        $display("txn reset-abort: responses=%0d", rsp_cnt);

        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_reader.md
Name: lcd_bus_reader

Overview:
- Read-side engine for the HD44780-style 16x2 LCD parallel bus. It is the counterpart of the existing init/write controller, which only ever drives the bus.
- Runs timed read cycles (RW=1) to fetch either the busy flag plus address counter (RS=0) or DDRAM/CGRAM data (RS=1).
- Optionally polls the busy flag until it clears, so the writer can stop using fixed delays.
- Sits beside the writer; `bus_active` tells the top-level bus mux to release DATA (tristate) and route this block's RS/RW/E.

Parameters:
- T_AS, 2: cycles RS/RW are stable before E rises (100 ns at 20 MHz).
- T_PW, 10: cycles E is held high; read data is sampled on the last of these.
- T_GAP, 20: cycles E is low after each pulse before the next pulse or completion.
- POLL_MAX, 20000: maximum busy-flag samples per request (used only with the optional feature).

Ports:
- clk, input, 1: system clock, 20 MHz.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, 1: read request.
- req_ready, output, 1: block idle, able to accept a request.
- req_rs, input, 1: 0 = busy-flag/address read, 1 = data read.
- req_wait_bf, input, 1: when req_rs=0, repeat reads until DB7=0.
- rsp_valid, output, 1: one-cycle completion pulse.
- rsp_data, output, 8: last sampled bus value.
- rsp_timeout, output, 1: valid with rsp_valid; polling gave up.
- bus_active, output, 1: block owns the LCD bus.
- lcd_rs, output, 1: LCD register select.
- lcd_rw, output, 1: LCD read/write (1 = read).
- lcd_e, output, 1: LCD enable strobe.
- lcd_db_in, input, 8: LCD data bus, input side of the top-level tristate.

Behaviour:
- Reset state: lcd_e=0, lcd_rw=0, lcd_rs=0, bus_active=0, rsp_valid=0, rsp_data=8'h00, rsp_timeout=0, req_ready=0. Internal state goes to IDLE and poll count to 0.
- Reset mid-operation: lcd_e is low on the first clock edge with rst high. No rsp_valid is issued for the aborted request.
- States: IDLE, SETUP, E_HIGH, HOLD, DONE.
- IDLE:
  - req_ready=1, bus outputs low.
  - Handshake is req_valid && req_ready. req_rs and req_wait_bf are captured on that edge; request inputs are ignored at all other times.
  - Next state is SETUP, with poll count set to 1.
- SETUP:
  - T_AS cycles; lcd_rs = captured rs, lcd_rw=1, lcd_e=0, bus_active=1.
- E_HIGH:
  - T_PW cycles with lcd_e=1.
  - lcd_db_in is registered on the final E_HIGH cycle, before E falls.
- HOLD:
  - T_GAP cycles; lcd_e=0, lcd_rw=1, lcd_rs held, bus_active=1.
  - Leaving HOLD: if captured rs=0 and wait_bf=1 and sample[7]=1, go back to SETUP and increment the poll count. Otherwise go to DONE.
  - wait_bf is ignored when rs=1.
- DONE:
  - Single cycle: rsp_valid=1, rsp_data=sample, bus_active=0, lcd_rw=0, lcd_rs=0. Then IDLE.
  - rsp_data holds its value until the next DONE.
  - There is no response backpressure.
- Timing counters are sized for values up to 2^16-1 and loaded with (parameter-1). All parameters must be at least 1.
- Single-read latency: request accepted at edge 0 gives rsp_valid in cycle T_AS+T_PW+T_GAP+1 (33 with defaults).
- Each extra poll adds T_AS+T_PW+T_GAP cycles (32).
- req_ready returns to 1 in the cycle after DONE, so back-to-back requests are spaced 34 cycles apart.

Optional Feature:
- Macro: LCD_BUSY_TIMEOUT_EN.
- Defined: on leaving HOLD with BF=1 and poll count == POLL_MAX, go to DONE with rsp_timeout=1; rsp_data holds the last sample. rsp_timeout is 0 for every other completion.
- Undefined: polling is unbounded, rsp_timeout is tied to 0, and the poll counter and POLL_MAX logic are not built.

Test Plan:
- rs=0, wait_bf=0, lcd_db_in=8'h25 → lcd_rw=1 in cycles 1–32, lcd_e high exactly in cycles 3–12, rsp_valid only in cycle 33, rsp_data=8'h25, rsp_timeout=0.
- rs=1, lcd_db_in=8'h48, wait_bf=1 → one E pulse only (wait_bf ignored), lcd_rs=1 in cycles 1–32, rsp_data=8'h48.
- rs=0, wait_bf=1, lcd_db_in=8'h80 for the first 3 samples, then 8'h07 → 4 E pulses 32 cycles apart, rsp_valid in cycle 129, rsp_data=8'h07.
- With LCD_BUSY_TIMEOUT_EN and POLL_MAX=4, lcd_db_in stuck at 8'hC0 → exactly 4 pulses, then rsp_valid with rsp_timeout=1 and rsp_data=8'hC0. Without the macro, pulses continue past 100.
- rst asserted for 1 cycle during cycle 7 (E high) → lcd_e, lcd_rw, bus_active all 0 in cycle 8, no rsp_valid, req_ready=1 in cycle 9.
- req_valid held high with 2 requests queued → req_ready low throughout the first transaction, second accepted in cycle 34, second rsp_valid in cycle 67.
